// File: rtl/ram_dump_pkg.sv
// rtl/ram_dump_pkg.sv - state type, default geometry and last-address helper for ram_dump_streamer
package ram_dump_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SEND, CHK, DONE} state_t;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_START_ADDR = 2;
   localparam int DEF_STRIDE     = 4;
   localparam int DEF_END_ADDR   = 65535;
   localparam int DEF_RD_LAT     = 1;

   // Down-counter width; holds RD_LAT-1 for RD_LAT in 1..4
   localparam int LAT_W = 2;

   function automatic int calc_last_addr(input int start_addr, input int stride, input int end_addr);
      return start_addr + ((end_addr - start_addr) / stride) * stride;
   endfunction

   localparam int LAST_ADDR = calc_last_addr(DEF_START_ADDR, DEF_STRIDE, DEF_END_ADDR);

endpackage

// File: rtl/ram_dump_streamer.sv
// rtl/ram_dump_streamer.sv - walks the data RAM after PROCESS_DONE and streams one byte per address
// Optional trailing two's-complement checksum beat when DUMP_CHECKSUM_EN is defined.
module ram_dump_streamer
   import ram_dump_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int START_ADDR = DEF_START_ADDR,
   parameter int STRIDE     = DEF_STRIDE,
   parameter int END_ADDR   = DEF_END_ADDR,
   parameter int RD_LAT     = DEF_RD_LAT
) (
   input  logic              MAIN_CLOCK,
   input  logic              RESET,
   input  logic              PROCESS_DONE,
   output logic [ADDR_W-1:0] ex_address,
   input  logic [DATA_W-1:0] ex_dataout,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic              dump_last,
   output logic              dump_busy,
   output logic              dump_done
);

   localparam logic [ADDR_W:0]  START_X  = (ADDR_W+1)'(START_ADDR);
   localparam logic [ADDR_W:0]  STRIDE_X = (ADDR_W+1)'(STRIDE);
   localparam logic [ADDR_W:0]  LAST_X   = (ADDR_W+1)'(calc_last_addr(START_ADDR, STRIDE, END_ADDR));
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

   state_t           state;
   logic [ADDR_W:0]  addr;
   logic [LAT_W-1:0] lat_cnt;
   logic             pd_prev;
   logic             pd_armed;
   logic             trigger;

   // A level already high when reset releases must not start a dump: the low phase has to be seen first
   assign trigger    = PROCESS_DONE & ~pd_prev & pd_armed;
   assign ex_address = addr[ADDR_W-1:0];

`ifdef DUMP_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_next;
   assign sum_next = sum + 8'(dump_data);
`endif

   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         addr       <= START_X;
         lat_cnt    <= '0;
         pd_prev    <= 1'b0;
         pd_armed   <= 1'b0;
         dump_data  <= '0;
         dump_valid <= 1'b0;
         dump_last  <= 1'b0;
         dump_busy  <= 1'b0;
         dump_done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         pd_prev <= PROCESS_DONE;
         if (!PROCESS_DONE) pd_armed <= 1'b1;
         case (state)
            IDLE, DONE: begin
               if (trigger) begin
                  state     <= WAIT;
                  addr      <= START_X;
                  lat_cnt   <= LAT_LOAD;
                  dump_busy <= 1'b1;
                  dump_done <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                  sum       <= '0;
`endif
               end
            end
            WAIT: begin
               if (lat_cnt == '0) state <= CAPTURE;
               else               lat_cnt <= lat_cnt - LAT_W'(1);
            end
            CAPTURE: begin
               dump_data  <= ex_dataout;
               dump_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
               dump_last  <= 1'b0;
`else
               dump_last  <= (addr == LAST_X);
`endif
               state      <= SEND;
            end
            SEND: begin
               if (dump_ready) begin
                  if (addr == LAST_X) begin
`ifdef DUMP_CHECKSUM_EN
                     state     <= CHK;
                     sum       <= sum_next;
                     dump_data <= DATA_W'(~sum_next + 8'd1);
                     dump_last <= 1'b1;
`else
                     state      <= DONE;
                     dump_valid <= 1'b0;
                     dump_last  <= 1'b0;
                     dump_busy  <= 1'b0;
                     dump_done  <= 1'b1;
`endif
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     sum        <= sum_next;
`endif
                     addr       <= addr + STRIDE_X;
                     lat_cnt    <= LAT_LOAD;
                     dump_valid <= 1'b0;
                     state      <= WAIT;
                  end
               end
            end
`ifdef DUMP_CHECKSUM_EN
            CHK: begin
               if (dump_ready) begin
                  state      <= DONE;
                  dump_valid <= 1'b0;
                  dump_last  <= 1'b0;
                  dump_busy  <= 1'b0;
                  dump_done  <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_dump_streamer.sv
// tb/tb_ram_dump_streamer.sv - directed table-driven bench for ram_dump_streamer (also builds with DUMP_CHECKSUM_EN)
module tb_ram_dump_streamer;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        last;
   } beat_t;

`ifdef DUMP_CHECKSUM_EN
   localparam int NA = 16385;
`else
   localparam int NA = 16384;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // instance A: default geometry
   logic        rst_a = 1'b1, pd_a = 1'b0, ready_a = 1'b1;
   logic [15:0] addr_a;
   logic [7:0]  dout_a, data_a;
   logic        valid_a, last_a, busy_a, done_a;

   // instance B: START=0 STRIDE=3 END=10, throttled sink
   logic        rst_b = 1'b1, pd_b = 1'b0, ready_b = 1'b0;
   logic [15:0] addr_b;
   logic [7:0]  dout_b, data_b;
   logic        valid_b, last_b, busy_b, done_b;

   // instance C: START=2 STRIDE=4 END=14 RD_LAT=3
   logic        rst_c = 1'b1, pd_c = 1'b0, ready_c = 1'b1;
   logic [15:0] addr_c;
   logic [7:0]  dout_c, data_c, p1_c, p2_c;
   logic        valid_c, last_c, busy_c, done_c;

   ram_dump_streamer u_a (
      .MAIN_CLOCK(clk), .RESET(rst_a), .PROCESS_DONE(pd_a), .ex_address(addr_a), .ex_dataout(dout_a),
      .dump_data(data_a), .dump_valid(valid_a), .dump_ready(ready_a), .dump_last(last_a),
      .dump_busy(busy_a), .dump_done(done_a));

   ram_dump_streamer #(.START_ADDR(0), .STRIDE(3), .END_ADDR(10), .RD_LAT(1)) u_b (
      .MAIN_CLOCK(clk), .RESET(rst_b), .PROCESS_DONE(pd_b), .ex_address(addr_b), .ex_dataout(dout_b),
      .dump_data(data_b), .dump_valid(valid_b), .dump_ready(ready_b), .dump_last(last_b),
      .dump_busy(busy_b), .dump_done(done_b));

   ram_dump_streamer #(.START_ADDR(2), .STRIDE(4), .END_ADDR(14), .RD_LAT(3)) u_c (
      .MAIN_CLOCK(clk), .RESET(rst_c), .PROCESS_DONE(pd_c), .ex_address(addr_c), .ex_dataout(dout_c),
      .dump_data(data_c), .dump_valid(valid_c), .dump_ready(ready_c), .dump_last(last_c),
      .dump_busy(busy_c), .dump_done(done_c));

   // RAM models with the configured read latency
   always @(posedge clk) dout_a <= addr_a[9:2];
   always @(posedge clk) dout_b <= addr_b[7:0] ^ 8'hA5;
   always @(posedge clk) begin
      p1_c   <= addr_c[9:2] + 8'd1;
      p2_c   <= p1_c;
      dout_c <= p2_c;
   end

   int rcnt_b = 0;
   always @(posedge clk) begin
      #1;
      rcnt_b  = (rcnt_b + 1) % 3;
      ready_b = (rcnt_b == 0);
   end

   int          beats_a = 0, bad_a = 0, lasts_a = 0, last_idx_a = -1, base_a = 0, k_a;
   logic [7:0]  exp_d_a;
   logic [15:0] exp_ad_a;
   always @(negedge clk) begin
      if (!rst_a && valid_a && ready_a) begin
         k_a = beats_a - base_a;
         if (k_a < 16384) begin
            exp_d_a  = k_a[7:0];
            exp_ad_a = 16'(2 + 4 * k_a);
         end else begin
            exp_d_a  = 8'h00;
            exp_ad_a = 16'd65534;
         end
         if (data_a !== exp_d_a || addr_a !== exp_ad_a) bad_a++;
         if (last_a) begin
            lasts_a++;
            last_idx_a = k_a;
         end
         beats_a++;
      end
   end

   beat_t      q_b[$];
   beat_t      q_c[$];
   logic       held_b = 1'b0, hl_b;
   logic [7:0] hd_b;
   int         stab_n = 0, stab_bad = 0;
   always @(negedge clk) begin
      beat_t bt;
      if (rst_b) held_b = 1'b0;
      else begin
         if (held_b) begin
            stab_n++;
            if (valid_b !== 1'b1 || data_b !== hd_b || last_b !== hl_b) stab_bad++;
         end
         if (valid_b && ready_b) begin
            bt = '{addr_b, data_b, last_b};
            q_b.push_back(bt);
            held_b = 1'b0;
         end else if (valid_b) begin
            held_b = 1'b1;
            hd_b   = data_b;
            hl_b   = last_b;
         end else held_b = 1'b0;
      end
   end

   always @(negedge clk) begin
      beat_t bt;
      if (!rst_c && valid_c && ready_c) begin
         bt = '{addr_c, data_c, last_c};
         q_c.push_back(bt);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_beats(input string tag, input beat_t exp_q[$], input beat_t got_q[$], input int base);
      check($sformatf("%s_count", tag), 32'(got_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < got_q.size()) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_q[base+i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_data%0d", tag, i), 32'(got_q[base+i].data), 32'(exp_q[i].data));
            check($sformatf("%s_last%0d", tag, i), 32'(got_q[base+i].last), 32'(exp_q[i].last));
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   beat_t tab_b[$];
   beat_t tab_c[$];
   int    lat, base, b4;

   initial begin
      tab_b.push_back('{16'd0, 8'hA5, 1'b0});
      tab_b.push_back('{16'd3, 8'hA6, 1'b0});
      tab_b.push_back('{16'd6, 8'hA3, 1'b0});
      tab_c.push_back('{16'd2, 8'h01, 1'b0});
      tab_c.push_back('{16'd6, 8'h02, 1'b0});
      tab_c.push_back('{16'd10, 8'h03, 1'b0});
`ifdef DUMP_CHECKSUM_EN
      tab_b.push_back('{16'd9, 8'hAC, 1'b0});
      tab_b.push_back('{16'd9, 8'h66, 1'b1});
      tab_c.push_back('{16'd14, 8'h04, 1'b0});
      tab_c.push_back('{16'd14, 8'hF6, 1'b1});
`else
      tab_b.push_back('{16'd9, 8'hAC, 1'b1});
      tab_c.push_back('{16'd14, 8'h04, 1'b1});
`endif

      // reset state
      repeat (2) @(negedge clk);
      check("rst_addr", 32'(addr_a), 32'd2);
      check("rst_data", 32'(data_a), 32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_last", 32'(last_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_addr_b", 32'(addr_b), 32'd0);
      check("rst_addr_c", 32'(addr_c), 32'd2);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      repeat (3) @(negedge clk);

      // T2: odd stride, sink ready one cycle in three
      for (int i = 0; i < 6 && rcnt_b != 1; i++) @(negedge clk);
      pd_b = 1'b1;
      for (int i = 0; i < 300 && !done_b; i++) @(negedge clk);
      check("t2_done", 32'(done_b), 32'd1);
      check("t2_busy", 32'(busy_b), 32'd0);
      cmp_beats("t2", tab_b, q_b, 0);
      check("t2_stall_seen", 32'(stab_n > 0), 32'd1);

      // T5: edge in DONE restarts, edge while busy is ignored
      base = q_b.size();
      pd_b = 1'b0;
      @(negedge clk) pd_b = 1'b1;
      @(negedge clk);
      check("t5_done_cleared", 32'(done_b), 32'd0);
      check("t5_busy", 32'(busy_b), 32'd1);
      pd_b = 1'b0;
      @(negedge clk) pd_b = 1'b1;
      for (int i = 0; i < 300 && !done_b; i++) @(negedge clk);
      check("t5_done", 32'(done_b), 32'd1);
      repeat (10) @(negedge clk);
      cmp_beats("t5", tab_b, q_b, base);
      check("t2_t5_stable_bad", 32'(stab_bad), 32'd0);

      // T3/T6: RD_LAT=3 latency and captured bytes
      pd_c = 1'b1;
      lat = 0;
      while (!valid_c && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("t3_latency", 32'(lat), 32'd5);
      for (int i = 0; i < 300 && !done_c; i++) @(negedge clk);
      check("t3_done", 32'(done_c), 32'd1);
      cmp_beats("t3", tab_c, q_c, 0);

      // T1: full default dump
      pd_a = 1'b1;
      lat = 0;
      while (!valid_a && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) check("t1_busy_rise", 32'(busy_a), 32'd1);
      end
      check("t1_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 60000 && !done_a; i++) @(negedge clk);
      check("t1_done", 32'(done_a), 32'd1);
      check("t1_beats", 32'(beats_a), 32'(NA));
      check("t1_bad_beats", 32'(bad_a), 32'd0);
      check("t1_last_count", 32'(lasts_a), 32'd1);
      check("t1_last_index", 32'(last_idx_a), 32'(NA - 1));
      check("t1_final_addr", 32'(addr_a), 32'd65534);
      check("t1_idle_busy", 32'(busy_a), 32'd0);
      check("t1_idle_valid", 32'(valid_a), 32'd0);

      // T4: asynchronous reset mid-dump, then no dump until a fresh edge
      pd_a = 1'b0;
      repeat (2) @(negedge clk);
      base_a = beats_a;
      pd_a = 1'b1;
      for (int i = 0; i < 1000 && !((beats_a - base_a) >= 100 && valid_a); i++) @(negedge clk);
      check("t4_mid_valid", 32'(valid_a), 32'd1);
      #2 rst_a = 1'b1;
      #1;
      check("t4_rst_addr", 32'(addr_a), 32'd2);
      check("t4_rst_data", 32'(data_a), 32'd0);
      check("t4_rst_valid", 32'(valid_a), 32'd0);
      check("t4_rst_last", 32'(last_a), 32'd0);
      check("t4_rst_busy", 32'(busy_a), 32'd0);
      check("t4_rst_done", 32'(done_a), 32'd0);
      b4 = beats_a;
      @(negedge clk) rst_a = 1'b0;
      repeat (20) @(negedge clk);
      check("t4_level_busy", 32'(busy_a), 32'd0);
      check("t4_level_valid", 32'(valid_a), 32'd0);
      check("t4_level_beats", 32'(beats_a - b4), 32'd0);
      pd_a = 1'b0;
      repeat (2) @(negedge clk);
      base_a = beats_a;
      pd_a = 1'b1;
      for (int i = 0; i < 10 && !valid_a; i++) @(negedge clk);
      check("t4_restart_valid", 32'(valid_a), 32'd1);
      rst_a = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
